sipo_byte_receiver: RTL and testbench
=====================================

SIPO_BYTE_RECEIVER -- requirements
Module: sipo_byte_receiver

Interface
REQ-001 Parameter MSB_FIRST, default 1, 1 = first received bit is data bit 7; 0 = first received bit is data bit 0.
REQ-002 Parameter AUTO_REARM, default 0, 1 = after a byte completes, stay in RECV for the next byte with no new frame_sync.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 serial_in  input  1  serial data bit, sampled only when bit_en=1.
REQ-006 bit_en  input  1  bit strobe; one bit consumed per cycle with bit_en=1.
REQ-007 frame_sync  input  1  qualified by bit_en; marks the current bit as the first bit of a byte.
REQ-008 clr_overrun  input  1  synchronous clear of the overrun flag.
REQ-009 out_ready  input  1  downstream accepts data_out when out_valid=1.
REQ-010 data_out  output  8  head of the output FIFO.
REQ-011 out_valid  output  1  FIFO non-empty.
REQ-012 busy  output  1  FSM in RECV.
REQ-013 overrun  output  1  sticky flag: a completed byte was dropped.
REQ-014 frame_err  output  1  one-cycle pulse: a byte was aborted by a resync.

Function
REQ-015 The FSM SHALL have two states: IDLE and RECV; busy = (state==RECV).
REQ-016 In IDLE, bit_en=1 with frame_sync=0 SHALL be ignored (no shift, no count change).
REQ-017 In IDLE, bit_en=1 with frame_sync=1 SHALL capture serial_in as bit 0 of the frame, set bit_cnt=1 and enter RECV.
REQ-018 In RECV, each bit_en=1 with frame_sync=0 SHALL shift serial_in into the shift register and increment the 3-bit bit_cnt.
  - MSB_FIRST=1: shift left, new bit enters the LSB.
  - MSB_FIRST=0: shift right, new bit enters the MSB.
REQ-019 In RECV, bit_en=1 with frame_sync=1 SHALL discard the partial byte, pulse frame_err for one cycle, and restart with this bit as the first bit (bit_cnt=1).
REQ-020 frame_sync on the 8th bit SHALL be treated as a resync per REQ-019; the partial byte is not pushed.
REQ-021 On the edge that captures the 8th bit, the assembled byte (shift register plus that bit) SHALL be written to the FIFO.
  - The byte appears on data_out with out_valid=1 on the next cycle when the FIFO was empty.
  - bit_cnt returns to 0.
REQ-022 After the 8th bit, the FSM SHALL go to IDLE if AUTO_REARM=0, or stay in RECV if AUTO_REARM=1.
REQ-023 The output FIFO SHALL be 2 entries deep, first-in first-out; data_out shows the oldest entry.
REQ-024 A pop SHALL occur on each edge with out_valid=1 and out_ready=1.
REQ-025 A push to a full FIFO with no simultaneous pop SHALL drop the byte and set overrun.
  - FIFO contents are unchanged.
REQ-026 A push and a pop on the same edge while full SHALL both succeed; count stays 2.
REQ-027 A push and a pop on the same edge with 1 entry SHALL output the new byte next cycle; count stays 1.
REQ-028 out_ready with out_valid=0 SHALL have no effect.
REQ-029 clr_overrun SHALL clear overrun; if set and clear coincide, set SHALL win.
REQ-030 When out_valid=0, data_out SHALL hold its last value (8'h00 after reset).

Reset
REQ-031 Asserting reset SHALL immediately force:
  - state=IDLE, bit_cnt=0, shift register=0;
  - FIFO empty, out_valid=0, data_out=8'h00;
  - busy=0, overrun=0, frame_err=0.
REQ-032 Reset mid-byte or with a full FIFO SHALL discard all partial and buffered data; the first byte after release requires frame_sync.

Verification
REQ-033 MSB_FIRST=1: frame_sync+bit_en, then bits 1,0,1,0,0,1,0,1 on consecutive strobes -> data_out=8'hA5 with out_valid=1 one cycle after the 8th bit; busy=0 afterwards.
REQ-034 MSB_FIRST=0: same bit sequence -> data_out=8'hA5.
REQ-035 out_ready=0, three bytes 8'h11, 8'h22, 8'h33 sent -> 8'h33 dropped, overrun=1.
  - Then out_ready=1 -> pops 8'h11 then 8'h22.
  - Then clr_overrun -> overrun=0.
REQ-036 frame_sync asserted after 5 bits of a byte -> frame_err=1 for exactly one cycle; the following 8 bits 8'h3C are received correctly; nothing pushed for the aborted byte.
REQ-037 AUTO_REARM=1: two back-to-back bytes 8'hF0, 8'h0F with a single frame_sync -> both delivered; busy stays 1.
REQ-038 Reset asserted mid-byte with 1 FIFO entry -> out_valid=0 and busy=0 immediately.
  - After release, bits without frame_sync are ignored.
  - A framed 8'h5A is then received correctly.

Source files
------------

// File: rtl/sipo_byte_receiver.sv
// Serial-in / parallel-out byte receiver.
// A frame_sync-qualified strobe marks the first bit of a byte. Eight strobed
// bits assemble one byte, which is written into a two-entry output FIFO.
// A frame_sync in the middle of a byte aborts it and reports frame_err.
// A byte completed while the FIFO is full and not draining is dropped and
// reported through the sticky overrun flag.
module sipo_byte_receiver #(
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit AUTO_REARM = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    input  logic       bit_en,
    input  logic       frame_sync,
    input  logic       clr_overrun,
    input  logic       out_ready,
    output logic [7:0] data_out,
    output logic       out_valid,
    output logic       busy,
    output logic       overrun,
    output logic       frame_err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Receiver FSM and assembly datapath
    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] bit_cnt_r;
    logic [2:0] bit_cnt_nxt_s;
    logic [7:0] shift_r;
    logic [7:0] shift_nxt_s;
    logic       push_s;
    logic [7:0] push_data_s;
    logic       frame_err_nxt_s;

    // Output FIFO: head_r is always the oldest entry and drives data_out
    logic [7:0] head_r;
    logic [7:0] head_nxt_s;
    logic [7:0] tail_r;
    logic [7:0] tail_nxt_s;
    logic [1:0] count_r;
    logic [1:0] count_nxt_s;
    logic       pop_s;
    logic       drop_s;
    logic       overrun_r;
    logic       overrun_nxt_s;
    logic       frame_err_r;
    logic       out_valid_r;
    logic       busy_r;

    // Shifts one received bit into a partially assembled byte in wire order.
    function automatic logic [7:0] shift_bit(input logic [7:0] cur, input logic b);
        logic [7:0] res;
        if (MSB_FIRST) begin
            res = {cur[6:0], b};
        end else begin
            res = {b, cur[7:1]};
        end
        return res;
    endfunction

    // Next-state and bit-assembly decisions for the receiver FSM
    always_comb begin
        state_nxt_s     = state_r;
        bit_cnt_nxt_s   = bit_cnt_r;
        shift_nxt_s     = shift_r;
        push_s          = 1'b0;
        push_data_s     = shift_bit(shift_r, serial_in);
        frame_err_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bit_en && frame_sync) begin
                    shift_nxt_s   = shift_bit(8'h00, serial_in);
                    bit_cnt_nxt_s = 3'd1;
                    state_nxt_s   = RECV;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RECV: begin
                if (bit_en) begin
                    if (frame_sync) begin
                        // Resync: the partial byte is abandoned, this bit starts a new one
                        shift_nxt_s     = shift_bit(8'h00, serial_in);
                        bit_cnt_nxt_s   = 3'd1;
                        frame_err_nxt_s = 1'b1;
                    end else if (bit_cnt_r == 3'd7) begin
                        push_s        = 1'b1;
                        bit_cnt_nxt_s = 3'd0;
                        shift_nxt_s   = 8'h00;
                        if (AUTO_REARM) begin
                            state_nxt_s = RECV;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end else begin
                        shift_nxt_s   = push_data_s;
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    state_nxt_s = RECV;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                bit_cnt_nxt_s = 3'd0;
                shift_nxt_s   = 8'h00;
            end
        endcase
    end

    // Receiver state, bit counter and shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
        end
    end

    // FIFO update: pop first, then push; a push into a full, non-draining FIFO is dropped
    always_comb begin
        pop_s       = (count_r != 2'd0) && out_ready;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        drop_s      = 1'b0;
        case (count_r)
            2'd0: begin
                if (push_s) begin
                    head_nxt_s  = push_data_s;
                    count_nxt_s = 2'd1;
                end else begin
                    count_nxt_s = 2'd0;
                end
            end
            2'd1: begin
                if (push_s && pop_s) begin
                    head_nxt_s = push_data_s;
                end else if (push_s) begin
                    tail_nxt_s  = push_data_s;
                    count_nxt_s = 2'd2;
                end else if (pop_s) begin
                    // head_r keeps the last value so data_out holds while empty
                    count_nxt_s = 2'd0;
                end else begin
                    count_nxt_s = 2'd1;
                end
            end
            2'd2: begin
                if (push_s && pop_s) begin
                    head_nxt_s = tail_r;
                    tail_nxt_s = push_data_s;
                end else if (push_s) begin
                    drop_s = 1'b1;
                end else if (pop_s) begin
                    head_nxt_s  = tail_r;
                    count_nxt_s = 2'd1;
                end else begin
                    count_nxt_s = 2'd2;
                end
            end
            default: begin
                count_nxt_s = 2'd0;
            end
        endcase
    end

    // Sticky overrun: a drop on the same edge as a clear keeps the flag set
    always_comb begin
        if (drop_s) begin
            overrun_nxt_s = 1'b1;
        end else if (clr_overrun) begin
            overrun_nxt_s = 1'b0;
        end else begin
            overrun_nxt_s = overrun_r;
        end
    end

    // FIFO storage and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r      <= 8'h00;
            tail_r      <= 8'h00;
            count_r     <= 2'd0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            head_r      <= head_nxt_s;
            tail_r      <= tail_nxt_s;
            count_r     <= count_nxt_s;
            overrun_r   <= overrun_nxt_s;
            frame_err_r <= frame_err_nxt_s;
            out_valid_r <= (count_nxt_s != 2'd0);
            busy_r      <= (state_nxt_s == RECV);
        end
    end

    assign data_out  = head_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_sipo_byte_receiver.sv
// Self-checking bench for sipo_byte_receiver. Three instances share the same
// stimulus: MSB-first, LSB-first, and MSB-first with auto re-arm. A queue-style
// reference model predicts every output of every instance after each clock.
module tb_sipo_byte_receiver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic serial_in;
    logic bit_en;
    logic frame_sync;
    logic clr_overrun;
    logic out_ready;

    logic [7:0] dout    [3];
    logic       valid_o [3];
    logic       busy_o  [3];
    logic       ovr_o   [3];
    logic       ferr_o  [3];

    sipo_byte_receiver #(.MSB_FIRST(1'b1), .AUTO_REARM(1'b0)) u0 (
        .clk(clk), .reset(reset), .serial_in(serial_in), .bit_en(bit_en),
        .frame_sync(frame_sync), .clr_overrun(clr_overrun), .out_ready(out_ready),
        .data_out(dout[0]), .out_valid(valid_o[0]), .busy(busy_o[0]),
        .overrun(ovr_o[0]), .frame_err(ferr_o[0]));

    sipo_byte_receiver #(.MSB_FIRST(1'b0), .AUTO_REARM(1'b0)) u1 (
        .clk(clk), .reset(reset), .serial_in(serial_in), .bit_en(bit_en),
        .frame_sync(frame_sync), .clr_overrun(clr_overrun), .out_ready(out_ready),
        .data_out(dout[1]), .out_valid(valid_o[1]), .busy(busy_o[1]),
        .overrun(ovr_o[1]), .frame_err(ferr_o[1]));

    sipo_byte_receiver #(.MSB_FIRST(1'b1), .AUTO_REARM(1'b1)) u2 (
        .clk(clk), .reset(reset), .serial_in(serial_in), .bit_en(bit_en),
        .frame_sync(frame_sync), .clr_overrun(clr_overrun), .out_ready(out_ready),
        .data_out(dout[2]), .out_valid(valid_o[2]), .busy(busy_o[2]),
        .overrun(ovr_o[2]), .frame_err(ferr_o[2]));

    localparam bit MSB_P [3] = '{1'b1, 1'b0, 1'b1};
    localparam bit AR_P  [3] = '{1'b0, 1'b0, 1'b1};

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model state, one slot per instance
    logic       in_frame_m [3];
    int         nbits_m    [3];
    logic [7:0] acc_m      [3];
    logic [7:0] fq_m       [3][2];
    int         cnt_m      [3];
    logic [7:0] shown_m    [3];
    logic       ovr_m      [3];
    logic       ferr_m     [3];

    task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            in_frame_m[i] = 1'b0;
            nbits_m[i]    = 0;
            acc_m[i]      = 8'h00;
            fq_m[i][0]    = 8'h00;
            fq_m[i][1]    = 8'h00;
            cnt_m[i]      = 0;
            shown_m[i]    = 8'h00;
            ovr_m[i]      = 1'b0;
            ferr_m[i]     = 1'b0;
        end
    endtask

    // Bit n of a frame lands in data bit 7-n (MSB first) or n (LSB first).
    task automatic model_step(input logic be, input logic fs, input logic sin,
                              input logic rdy, input logic clr);
        for (int i = 0; i < 3; i++) begin
            logic       pop;
            logic       push;
            logic       drop;
            logic [7:0] pv;
            int         pos;
            pop  = (cnt_m[i] > 0) && rdy;
            push = 1'b0;
            drop = 1'b0;
            pv   = 8'h00;
            ferr_m[i] = 1'b0;
            if (be) begin
                if (fs) begin
                    if (in_frame_m[i]) ferr_m[i] = 1'b1;
                    in_frame_m[i] = 1'b1;
                    acc_m[i]      = 8'h00;
                    nbits_m[i]    = 0;
                end
                if (fs || in_frame_m[i]) begin
                    pos = MSB_P[i] ? (7 - nbits_m[i]) : nbits_m[i];
                    acc_m[i][pos] = sin;
                    nbits_m[i]++;
                    if (nbits_m[i] == 8) begin
                        push = 1'b1;
                        pv   = acc_m[i];
                        nbits_m[i] = 0;
                        acc_m[i]   = 8'h00;
                        if (!AR_P[i]) in_frame_m[i] = 1'b0;
                    end
                end
            end
            if (push && (cnt_m[i] == 2) && !pop) drop = 1'b1;
            if (pop) begin
                fq_m[i][0] = fq_m[i][1];
                cnt_m[i]--;
            end
            if (push && !drop) begin
                fq_m[i][cnt_m[i]] = pv;
                cnt_m[i]++;
            end
            if (cnt_m[i] > 0) shown_m[i] = fq_m[i][0];
            if (clr) ovr_m[i] = 1'b0;
            if (drop) ovr_m[i] = 1'b1;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check_value($sformatf("u%0d data_out", i), dout[i], shown_m[i]);
            check_value($sformatf("u%0d out_valid", i), {7'd0, valid_o[i]}, {7'd0, (cnt_m[i] > 0)});
            check_value($sformatf("u%0d busy", i), {7'd0, busy_o[i]}, {7'd0, in_frame_m[i]});
            check_value($sformatf("u%0d overrun", i), {7'd0, ovr_o[i]}, {7'd0, ovr_m[i]});
            check_value($sformatf("u%0d frame_err", i), {7'd0, ferr_o[i]}, {7'd0, ferr_m[i]});
        end
    endtask

    // Drives one cycle of inputs, advances the model, samples 1 ns after the edge.
    task automatic cycle(input logic be, input logic fs, input logic sin,
                         input logic rdy, input logic clr);
        bit_en      = be;
        frame_sync  = fs;
        serial_in   = sin;
        out_ready   = rdy;
        clr_overrun = clr;
        model_step(be, fs, sin, rdy, clr);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Sends a byte on the wire in bit7..bit0 order, first bit optionally framed.
    task automatic send_byte(input logic [7:0] v, input logic framed, input logic rdy);
        for (int b = 7; b >= 0; b--) begin
            cycle(1'b1, framed && (b == 7), v[b], rdy, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] v;
        reset       = 1'b1;
        serial_in   = 1'b0;
        bit_en      = 1'b0;
        frame_sync  = 1'b0;
        clr_overrun = 1'b0;
        out_ready   = 1'b0;
        model_reset();
        #2;
        compare_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;

        // Unframed strobes in IDLE are ignored
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, k[0], 1'b0, 1'b0);

        // 1,0,1,0,0,1,0,1 gives 8'hA5 in either bit order
        send_byte(8'hA5, 1'b1, 1'b0);
        check_value("msb_first A5", dout[0], 8'hA5);
        check_value("lsb_first A5", dout[1], 8'hA5);
        check_value("A5 valid", {7'd0, valid_o[0]}, 8'h01);
        check_value("A5 busy after", {7'd0, busy_o[0]}, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Three bytes into a stalled FIFO: the third is dropped
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0);
        check_value("ovr set", {7'd0, ovr_o[0]}, 8'h01);
        check_value("ovr head", dout[0], 8'h11);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_value("ovr pop1", dout[0], 8'h22);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_value("ovr empty", {7'd0, valid_o[0]}, 8'h00);
        check_value("ovr hold", dout[0], 8'h22);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_value("ovr clear", {7'd0, ovr_o[0]}, 8'h00);

        // Resync after five bits, then a clean 8'h3C
        v = 8'hFF;
        for (int b = 7; b >= 3; b--) cycle(1'b1, (b == 7), v[b], 1'b1, 1'b0);
        v = 8'h3C;
        cycle(1'b1, 1'b1, v[7], 1'b1, 1'b0);
        check_value("resync ferr", {7'd0, ferr_o[0]}, 8'h01);
        for (int b = 6; b >= 0; b--) begin
            cycle(1'b1, 1'b0, v[b], 1'b1, 1'b0);
            if (b == 6) check_value("resync ferr drop", {7'd0, ferr_o[0]}, 8'h00);
        end
        check_value("resync 3C", dout[0], 8'h3C);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Auto re-arm: two bytes behind one frame_sync
        send_byte(8'hF0, 1'b1, 1'b0);
        check_value("rearm F0", dout[2], 8'hF0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_byte(8'h0F, 1'b0, 1'b0);
        check_value("rearm 0F", dout[2], 8'h0F);
        check_value("rearm busy", {7'd0, busy_o[2]}, 8'h01);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-byte with one buffered entry
        send_byte(8'h77, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check_value("rst valid", {7'd0, valid_o[0]}, 8'h00);
        check_value("rst busy", {7'd0, busy_o[0]}, 8'h00);
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_value("post rst idle", {7'd0, busy_o[0]}, 8'h00);
        send_byte(8'h5A, 1'b1, 1'b0);
        check_value("post rst 5A", dout[0], 8'h5A);

        // Randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 31) == 0));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
